// File: rtl/brew_dram_responder_if.sv
// Multiplexed RAS/CAS bus between the Brew V1 CPU (master) and a DRAM bank (slave).
interface brew_dram_responder_if;
  logic        dram_n_ras;
  logic        dram_n_cas_0;
  logic        dram_n_cas_1;
  logic [10:0] dram_addr;
  logic        dram_n_we;
  logic [7:0]  dram_data_in;
  logic [7:0]  dram_data_out;
  logic        dram_data_out_en;
  logic        dram_n_wait;

  modport master (
    output dram_n_ras, dram_n_cas_0, dram_n_cas_1, dram_addr, dram_n_we, dram_data_in,
    input  dram_data_out, dram_data_out_en, dram_n_wait
  );

  modport slave (
    input  dram_n_ras, dram_n_cas_0, dram_n_cas_1, dram_addr, dram_n_we, dram_data_in,
    output dram_data_out, dram_data_out_en, dram_n_wait
  );
endinterface

// File: rtl/brew_dram_responder.sv
// Synchronous DRAM bank model: latches row/column from the strobes, serves byte
// reads/writes from an internal array and stretches accesses with wait states.
module brew_dram_responder #(
  parameter int ROW_BITS    = 4,
  parameter int COL_BITS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  brew_dram_responder_if.slave  bus,
  output logic                  proto_err
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS + 1;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam bit HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_WAIT = 2'd2,
    ST_XFER = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  ras_q_r;
  logic                  cas0_q_r;
  logic                  cas1_q_r;
  logic [ROW_BITS-1:0]   row_r;
  logic [COL_BITS-1:0]   col_r;
  logic                  lane_r;
  logic                  we_n_r;
  logic [3:0]            cnt_r;
  logic                  first_r;
  logic [7:0]            data_out_r;
  logic                  data_out_en_r;
  logic                  n_wait_r;
  logic                  proto_err_r;
  logic [7:0]            mem_r [DEPTH];

  logic                  ras_fall_s;
  logic                  cas_fall_s;
  logic                  cas_high_s;
  logic                  wr_en_s;
  logic [ADDR_BITS-1:0]  acc_addr_s;
  logic                  unused_addr_s;

  assign ras_fall_s    = !bus.dram_n_ras && ras_q_r;
  assign cas_fall_s    = cas0_q_r && cas1_q_r && (!bus.dram_n_cas_0 || !bus.dram_n_cas_1);
  assign cas_high_s    = bus.dram_n_cas_0 && bus.dram_n_cas_1;
  assign acc_addr_s    = {row_r, col_r, lane_r};
  // One commit per CAS cycle, on the first XFER cycle, dropped by RAS rise or reset.
  assign wr_en_s       = (state_r == ST_XFER) && first_r && !we_n_r && !bus.dram_n_ras && !rst;
  assign unused_addr_s = ^bus.dram_addr;

  assign bus.dram_data_out    = data_out_r;
  assign bus.dram_data_out_en = data_out_en_r;
  assign bus.dram_n_wait      = n_wait_r;
  assign proto_err            = proto_err_r;

  // Next-state selection; a high RAS sample overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.dram_n_ras) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ras_fall_s ? ST_ROW : ST_IDLE;
        ST_ROW: begin
          if (cas_fall_s) begin
            state_nxt_s = HAS_WAIT ? ST_WAIT : ST_XFER;
          end else begin
            state_nxt_s = ST_ROW;
          end
        end
        ST_WAIT: begin
          if (cas_high_s) begin
            state_nxt_s = ST_ROW;
          end else if (cnt_r == 4'd0) begin
            state_nxt_s = ST_XFER;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_XFER: state_nxt_s = cas_high_s ? ST_ROW : ST_XFER;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Access FSM with strobe history and all registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ras_q_r       <= 1'b1;
      cas0_q_r      <= 1'b1;
      cas1_q_r      <= 1'b1;
      row_r         <= '0;
      col_r         <= '0;
      lane_r        <= 1'b0;
      we_n_r        <= 1'b1;
      cnt_r         <= 4'd0;
      first_r       <= 1'b0;
      data_out_r    <= 8'h00;
      data_out_en_r <= 1'b0;
      n_wait_r      <= 1'b1;
      proto_err_r   <= 1'b0;
    end else begin
      ras_q_r  <= bus.dram_n_ras;
      cas0_q_r <= bus.dram_n_cas_0;
      cas1_q_r <= bus.dram_n_cas_1;
      state_r  <= state_nxt_s;
      first_r  <= (state_nxt_s == ST_XFER) && (state_r != ST_XFER);
      n_wait_r <= (state_nxt_s != ST_WAIT);

      if ((state_r == ST_IDLE) && ras_fall_s) begin
        row_r <= bus.dram_addr[ROW_BITS-1:0];
      end

      if ((state_r == ST_ROW) && !bus.dram_n_ras && cas_fall_s) begin
        col_r  <= bus.dram_addr[COL_BITS-1:0];
        // Lane 1 only when CAS 0 stayed high; a double strobe falls back to lane 0.
        lane_r <= bus.dram_n_cas_0;
        we_n_r <= bus.dram_n_we;
        cnt_r  <= WAIT_LOAD;
        if (!bus.dram_n_cas_0 && !bus.dram_n_cas_1) begin
          proto_err_r <= 1'b1;
        end
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end

      if ((state_r == ST_XFER) && (state_nxt_s == ST_XFER) && we_n_r) begin
        data_out_r    <= mem_r[acc_addr_s];
        data_out_en_r <= 1'b1;
      end else begin
        data_out_en_r <= 1'b0;
      end
    end
  end

  // Byte array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[acc_addr_s] <= bus.dram_data_in;
    end
  end

endmodule

// File: tb/tb_brew_dram_responder.sv
// Directed bench driving one bus into two banks (no wait states and three wait states).
module tb_brew_dram_responder;

  logic        clk;
  logic        rst;
  logic        ras;
  logic        cas0;
  logic        cas1;
  logic        we_n;
  logic [10:0] addr;
  logic [7:0]  din;
  logic        perr0;
  logic        perr3;

  int tests;
  int failed;

  logic [5:0] en0_h, en3_h, wt0_h, wt3_h;
  logic [7:0] dout0, dout3;
  logic       en0_post, en3_post;
  logic [7:0] val;

  brew_dram_responder_if bus0 ();
  brew_dram_responder_if bus3 ();

  assign bus0.dram_n_ras   = ras;
  assign bus0.dram_n_cas_0 = cas0;
  assign bus0.dram_n_cas_1 = cas1;
  assign bus0.dram_addr    = addr;
  assign bus0.dram_n_we    = we_n;
  assign bus0.dram_data_in = din;
  assign bus3.dram_n_ras   = ras;
  assign bus3.dram_n_cas_0 = cas0;
  assign bus3.dram_n_cas_1 = cas1;
  assign bus3.dram_addr    = addr;
  assign bus3.dram_n_we    = we_n;
  assign bus3.dram_data_in = din;

  brew_dram_responder #(.ROW_BITS(4), .COL_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .proto_err(perr0)
  );

  brew_dram_responder #(.ROW_BITS(4), .COL_BITS(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .proto_err(perr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic open_row(input logic [10:0] a);
    addr = a;
    ras  = 1'b0;
    tick();
  endtask

  task automatic close_row();
    ras = 1'b1;
    tick();
    tick();
  endtask

  // Six cycles of CAS low (bit i of each history = after edge T0+i), then one cycle high.
  task automatic cas_cycle(input logic [10:0] a, input logic c0, input logic c1,
                           input logic nwe, input logic [7:0] d);
    addr = a;
    we_n = nwe;
    din  = d;
    cas0 = c0;
    cas1 = c1;
    for (int i = 0; i < 6; i++) begin
      tick();
      en0_h[i] = bus0.dram_data_out_en;
      en3_h[i] = bus3.dram_data_out_en;
      wt0_h[i] = bus0.dram_n_wait;
      wt3_h[i] = bus3.dram_n_wait;
    end
    dout0 = bus0.dram_data_out;
    dout3 = bus3.dram_data_out;
    cas0 = 1'b1;
    cas1 = 1'b1;
    we_n = 1'b1;
    tick();
    en0_post = bus0.dram_data_out_en;
    en3_post = bus3.dram_data_out_en;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst  = 1'b1;
    ras  = 1'b1;
    cas0 = 1'b1;
    cas1 = 1'b1;
    we_n = 1'b1;
    addr = 11'h000;
    din  = 8'h00;
    tick();
    tick();
    check("rst_wait0", {7'd0, bus0.dram_n_wait}, 8'h01);
    check("rst_en0", {7'd0, bus0.dram_data_out_en}, 8'h00);
    check("rst_dout0", bus0.dram_data_out, 8'h00);
    check("rst_err0", {7'd0, perr0}, 8'h00);
    check("rst_wait3", {7'd0, bus3.dram_n_wait}, 8'h01);
    check("rst_en3", {7'd0, bus3.dram_data_out_en}, 8'h00);
    rst = 1'b0;
    tick();

    // Single write then read, lane 1; the read row/col carry junk upper bits.
    open_row(11'd3);
    cas_cycle(11'h012, 1'b1, 1'b0, 1'b0, 8'hA5);
    check("wr_no_drive0", {2'b00, en0_h}, 8'h00);
    check("wr_no_drive3", {2'b00, en3_h}, 8'h00);
    close_row();
    open_row(11'h7F3);
    cas_cycle(11'h512, 1'b1, 1'b0, 1'b1, 8'h00);
    check("rd_a5_d0", dout0, 8'hA5);
    check("rd_a5_d3", dout3, 8'hA5);
    check("rd_en_hist0", {2'b00, en0_h}, 8'h3E);
    check("rd_nowait0", {2'b00, wt0_h}, 8'h3F);
    check("rd_en_fall0", {7'd0, en0_post}, 8'h00);
    check("rd_en_fall3", {7'd0, en3_post}, 8'h00);
    close_row();

    // Page-mode burst: four writes in one row, then read back in a second row cycle.
    open_row(11'd7);
    val = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cas_cycle(11'(i), 1'b0, 1'b1, 1'b0, val);
      val = val + 8'h11;
    end
    close_row();
    open_row(11'd7);
    val = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cas_cycle(11'(i), 1'b0, 1'b1, 1'b1, 8'h00);
      check("burst_d0", dout0, val);
      check("burst_d3", dout3, val);
      if (i == 0) begin
        check("wait_hist3", {2'b00, wt3_h}, 8'h38);
        check("en_hist3", {2'b00, en3_h}, 8'h30);
      end
      val = val + 8'h11;
    end
    close_row();

    // CAS released inside the wait window: the slow bank must not commit.
    open_row(11'd7);
    addr = 11'h000;
    we_n = 1'b0;
    din  = 8'h77;
    cas0 = 1'b0;
    tick();
    tick();
    check("abort_wait_low3", {7'd0, bus3.dram_n_wait}, 8'h00);
    cas0 = 1'b1;
    we_n = 1'b1;
    tick();
    check("abort_wait_rel3", {7'd0, bus3.dram_n_wait}, 8'h01);
    check("abort_no_drive3", {7'd0, bus3.dram_data_out_en}, 8'h00);
    tick();
    cas_cycle(11'h000, 1'b0, 1'b1, 1'b1, 8'h00);
    check("abort_keep3", dout3, 8'h11);
    check("abort_fast0", dout0, 8'h77);
    close_row();

    // CAS-before-RAS refresh with both strobes low.
    cas0 = 1'b0;
    cas1 = 1'b0;
    tick();
    tick();
    tick();
    check("cbr_en0", {7'd0, bus0.dram_data_out_en}, 8'h00);
    check("cbr_en3", {7'd0, bus3.dram_data_out_en}, 8'h00);
    check("cbr_wait3", {7'd0, bus3.dram_n_wait}, 8'h01);
    ras = 1'b0;
    tick();
    ras = 1'b1;
    tick();
    cas0 = 1'b1;
    cas1 = 1'b1;
    tick();
    tick();
    check("cbr_err0", {7'd0, perr0}, 8'h00);
    check("cbr_err3", {7'd0, perr3}, 8'h00);

    // Double CAS strobe: error flag, lane 0 written, lane 1 untouched.
    open_row(11'd5);
    cas_cycle(11'h020, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pe_clean0", {7'd0, perr0}, 8'h00);
    cas_cycle(11'h020, 1'b0, 1'b0, 1'b0, 8'h5A);
    check("pe_set0", {7'd0, perr0}, 8'h01);
    check("pe_set3", {7'd0, perr3}, 8'h01);
    close_row();
    tick();
    tick();
    open_row(11'd5);
    cas_cycle(11'h020, 1'b0, 1'b1, 1'b1, 8'h00);
    check("pe_lane0_d0", dout0, 8'h5A);
    check("pe_lane0_d3", dout3, 8'h5A);
    cas_cycle(11'h020, 1'b1, 1'b0, 1'b1, 8'h00);
    check("pe_lane1_d0", dout0, 8'h00);
    check("pe_lane1_d3", dout3, 8'h00);
    close_row();
    check("pe_sticky0", {7'd0, perr0}, 8'h01);
    check("pe_sticky3", {7'd0, perr3}, 8'h01);
    rst = 1'b1;
    tick();
    check("pe_clr0", {7'd0, perr0}, 8'h00);
    check("pe_clr3", {7'd0, perr3}, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
